// File: rtl/condiciona_chaves.sv
// Player switch conditioning: 2-flop synchronisers, per-bit debounce,
// rising-edge capture into a pending set, and a two-state handshake that
// presents accumulated presses to the game engine as a single command.
module condiciona_chaves #(
  parameter int unsigned DEBOUNCE_CICLOS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] chaves_brutas,
  input  logic       habilita,
  input  logic       comando_ack,
  output logic [5:0] comando,
  output logic       comando_valido,
  output logic [5:0] chaves_estaveis,
  output logic [3:0] db_descartes,
  output logic [3:0] db_estado
);

  // Counter only ever holds 0..DEBOUNCE_CICLOS-1.
  localparam int unsigned CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    VALIDO = 1'b1
  } estado_t;

  estado_t           estado, estado_next;
  logic [5:0]        sync_a, sync_b;
  logic [5:0][CW-1:0] cnt, cnt_next;
  logic [5:0]        estaveis_next;
  logic [5:0]        subida;
  logic [5:0]        pendente, pendente_next;
  logic [5:0]        mascara;
  logic [5:0]        perdidos;
  logic [3:0]        descartes_next;
  logic [4:0]        soma;
  logic              carrega, limpa;

  // Two-flop synchroniser on every raw switch bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= chaves_brutas;
      sync_b <= sync_a;
    end
  end

  // Debounce: accept the synchronised level after DEBOUNCE_CICLOS consecutive mismatches.
  always_comb begin
    estaveis_next = chaves_estaveis;
    cnt_next      = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (sync_b[i] != chaves_estaveis[i]) begin
        if (cnt[i] == LIMITE) begin
          estaveis_next[i] = sync_b[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge is taken from the accepting transition itself so the pending
  // bit is set on the same edge the stable level rises.
  assign subida = estaveis_next & ~chaves_estaveis;

  // Debounce state and stable levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt             <= '0;
      chaves_estaveis <= '0;
    end else begin
      cnt             <= cnt_next;
      chaves_estaveis <= estaveis_next;
    end
  end

  // Handshake FSM: next state and load/clear strobes.
  always_comb begin
    estado_next = estado;
    carrega     = 1'b0;
    limpa       = 1'b0;
    case (estado)
      OCIOSO: begin
        if (habilita && (pendente != '0)) begin
          carrega     = 1'b1;
          estado_next = VALIDO;
        end
      end
      VALIDO: begin
        if (!habilita || comando_ack) begin
          limpa       = 1'b1;
          estado_next = OCIOSO;
        end
      end
      default: estado_next = OCIOSO;
    endcase
  end

  // Pending set update and merged-press accounting; a bit being loaded this
  // cycle is free to re-arm from a simultaneous edge without counting as lost.
  always_comb begin
    mascara       = carrega ? pendente : '0;
    pendente_next = '0;
    perdidos      = '0;
    if (habilita) begin
      pendente_next = (pendente & ~mascara) | subida;
      perdidos      = subida & pendente & ~mascara;
    end
    soma = {1'b0, db_descartes};
    for (int unsigned i = 0; i < 6; i++) begin
      soma = soma + {4'b0000, perdidos[i]};
    end
    descartes_next = (soma > 5'd15) ? 4'hF : soma[3:0];
  end

  // State, pending set, presented command and discard counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      pendente     <= '0;
      comando      <= '0;
      db_descartes <= '0;
    end else begin
      estado       <= estado_next;
      pendente     <= pendente_next;
      db_descartes <= descartes_next;
      if (carrega) begin
        comando <= pendente;
      end else if (limpa) begin
        comando <= '0;
      end
    end
  end

  assign comando_valido = (estado == VALIDO);
  assign db_estado      = {3'b000, estado};

endmodule

// File: tb/tb_condiciona_chaves.sv
// Bench for condiciona_chaves: directed scenarios followed by random switch
// activity, checked against a history-based behavioural model.
module tb_condiciona_chaves;

  localparam int unsigned D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] chaves_brutas;
  logic       habilita;
  logic       comando_ack;
  logic [5:0] comando;
  logic       comando_valido;
  logic [5:0] chaves_estaveis;
  logic [3:0] db_descartes;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  condiciona_chaves #(.DEBOUNCE_CICLOS(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .chaves_brutas   (chaves_brutas),
    .habilita        (habilita),
    .comando_ack     (comando_ack),
    .comando         (comando),
    .comando_valido  (comando_valido),
    .chaves_estaveis (chaves_estaveis),
    .db_descartes    (db_descartes),
    .db_estado       (db_estado)
  );

  int checks = 0;
  int errors = 0;
  int n_present = 0;
  int base;

  logic [5:0] exp_q[$];

  // Reference model state
  logic [5:0] hist[$];
  logic [5:0] m_stable = '0;
  logic [5:0] m_pend = '0;
  logic [5:0] m_cmd = '0;
  logic       m_pres = 1'b0;
  int         m_desc = 0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, want, $time);
    end
  endtask

  // Behavioural model: a stable level flips once the last D synchronised
  // samples (raw delayed by two edges) all disagree with it.
  always @(posedge clock) begin : modelo
    logic [5:0] old, rise, mask, lost;
    bit load, diff;
    int idx;
    if (reset) begin
      hist.delete();
      m_stable = '0;
      m_pend   = '0;
      m_cmd    = '0;
      m_pres   = 1'b0;
      m_desc   = 0;
    end else begin
      hist.push_back(chaves_brutas);
      if (hist.size() > D + 4) void'(hist.pop_front());
      old = m_stable;
      if (hist.size() >= D + 2) begin
        for (int b = 0; b < 6; b++) begin
          diff = 1'b1;
          for (int j = 0; j < int'(D); j++) begin
            idx = hist.size() - 3 - j;
            if (hist[idx][b] == old[b]) diff = 1'b0;
          end
          if (diff) m_stable[b] = ~old[b];
        end
      end
      rise = m_stable & ~old;
      if (!habilita) begin
        m_pend = '0;
        if (m_pres) begin
          m_pres = 1'b0;
          m_cmd  = '0;
        end
      end else begin
        load = !m_pres && (m_pend != '0);
        mask = load ? m_pend : 6'b000000;
        lost = rise & m_pend & ~mask;
        m_desc = m_desc + $countones(lost);
        if (m_desc > 15) m_desc = 15;
        if (m_pres && comando_ack) begin
          m_pres = 1'b0;
          m_cmd  = '0;
        end
        if (load) begin
          m_cmd  = m_pend;
          m_pres = 1'b1;
          exp_q.push_back(m_pend);
        end
        m_pend = (m_pend & ~mask) | rise;
      end
    end
  end

  // Monitor: per-cycle output comparison and scoreboard pop on each new command.
  always @(posedge clock) begin
    #1;
    chk("ciclo",
        {11'b0, comando_valido, comando, chaves_estaveis, db_descartes, db_estado},
        {11'b0, m_pres, m_cmd, m_stable, m_desc[3:0], 3'b000, m_pres});
    if (comando_valido && !prev_valid) begin
      n_present++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got command %b expected none at %0t", comando, $time);
      end else begin
        chk("comando_sb", {26'b0, comando}, {26'b0, exp_q.pop_front()});
      end
    end
    prev_valid = comando_valido;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    chaves_brutas = '0;
    habilita      = 1'b0;
    comando_ack   = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_comando",   {26'b0, comando}, 32'd0);
    chk("reset_valido",    {31'b0, comando_valido}, 32'd0);
    chk("reset_estaveis",  {26'b0, chaves_estaveis}, 32'd0);
    chk("reset_descartes", {28'b0, db_descartes}, 32'd0);
    chk("reset_estado",    {28'b0, db_estado}, 32'd0);
    reset = 1'b0; habilita = 1'b1; comando_ack = 1'b1;
    repeat (2) @(negedge clock);

    // Two-bit press with ack tied high: single-cycle command after edge 7
    chaves_brutas = 6'b100001;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock); #1;
      chk("lat_valido", {31'b0, comando_valido}, {31'b0, (e == 7)});
      if (e == 7) chk("lat_comando", {26'b0, comando}, 32'b100001);
    end
    @(negedge clock); chaves_brutas = '0;
    repeat (12) @(negedge clock);

    // Short glitch is rejected
    base = n_present;
    chaves_brutas = 6'b000001;
    repeat (3) @(negedge clock);
    chaves_brutas = '0;
    repeat (12) @(negedge clock);
    chk("pulso_estaveis", {26'b0, chaves_estaveis}, 32'd0);
    chk("pulso_sem_comando", n_present - base, 32'd0);

    // Re-press while presenting stays pending; a third press is merged
    comando_ack = 1'b0; base = n_present;
    chaves_brutas = 6'b000010; repeat (8) @(negedge clock);
    chk("r31_valido", {31'b0, comando_valido}, 32'd1);
    chk("r31_comando", {26'b0, comando}, 32'b000010);
    chaves_brutas = '0;        repeat (8) @(negedge clock);
    chaves_brutas = 6'b000010; repeat (8) @(negedge clock);
    chk("r31_descartes", {28'b0, db_descartes}, 32'd0);
    chk("r31_comando_estavel", {26'b0, comando}, 32'b000010);
    chaves_brutas = '0;        repeat (8) @(negedge clock);
    chaves_brutas = 6'b000010; repeat (8) @(negedge clock);
    chk("r32_descartes", {28'b0, db_descartes}, 32'd1);
    comando_ack = 1'b1; repeat (12) @(negedge clock);
    chaves_brutas = '0; repeat (10) @(negedge clock);
    chk("r32_total", n_present - base, 32'd2);

    // habilita dropped while presenting; presses while disabled are ignored
    comando_ack = 1'b0; base = n_present;
    chaves_brutas = 6'b001000; repeat (8) @(negedge clock);
    chk("r33_valido", {31'b0, comando_valido}, 32'd1);
    habilita = 1'b0;
    @(posedge clock); #1;
    chk("r33_valido_baixo", {31'b0, comando_valido}, 32'd0);
    chk("r33_comando_zero", {26'b0, comando}, 32'd0);
    @(negedge clock);
    chaves_brutas = 6'b010000; repeat (10) @(negedge clock);
    chaves_brutas = '0;        repeat (10) @(negedge clock);
    chaves_brutas = 6'b010000; repeat (10) @(negedge clock);
    habilita = 1'b1;           repeat (15) @(negedge clock);
    chk("r33_total", n_present - base, 32'd1);
    chaves_brutas = '0; repeat (10) @(negedge clock);

    // Discard counter saturates at 15
    for (int k = 0; k < 18; k++) begin
      chaves_brutas = 6'b100000; repeat (7) @(negedge clock);
      chaves_brutas = '0;        repeat (7) @(negedge clock);
    end
    chk("sat_descartes", {28'b0, db_descartes}, 32'd15);
    chk("sat_comando", {26'b0, comando}, 32'b100000);

    // Reset while presenting with bit2 held: fresh debounce, one command
    chaves_brutas = 6'b000100; repeat (8) @(negedge clock);
    reset = 1'b1; #1;
    chk("r34_reset_out", {11'b0, comando_valido, comando, chaves_estaveis, db_descartes, db_estado}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock); #1;
      chk("r34_latencia", {31'b0, comando_valido}, {31'b0, (e >= 7)});
      if (e == 7) chk("r34_comando", {26'b0, comando}, 32'b000100);
    end
    @(negedge clock);
    comando_ack = 1'b1; repeat (5) @(negedge clock);
    chaves_brutas = '0; repeat (10) @(negedge clock);

    // Random activity
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int b;
        b = $urandom_range(0, 5);
        chaves_brutas[b] = ~chaves_brutas[b];
      end
      if ($urandom_range(0, 39) == 0) habilita = ~habilita;
      comando_ack = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clock);
    end
    reset = 1'b0; habilita = 1'b1; comando_ack = 1'b1; chaves_brutas = '0;
    repeat (20) @(negedge clock);
    chk("fila_vazia", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/condiciona_chaves.md
CONDICIONA_CHAVES -- requirements
Module: condiciona_chaves

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 4, is the consecutive-cycle count needed to accept a new switch level; board builds override it, range 1..2^20.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 chaves_brutas  input  6  raw, unsynchronised player buttons (movement, fire).
REQ-005 habilita  input  1  game-in-progress qualifier, tied to the game engine's jogo_base_em_andamento.
REQ-006 comando_ack  input  1  consumer accepts the presented command.
REQ-007 comando  output  6  one-hot-or-combined press vector presented to the game engine.
REQ-008 comando_valido  output  1  comando holds a valid, unaccepted command.
REQ-009 chaves_estaveis  output  6  debounced switch levels.
REQ-010 db_descartes  output  4  saturating count of merged (lost) presses.
REQ-011 db_estado  output  4  FSM state code: OCIOSO=0, VALIDO=1.

Function
REQ-012 Each chaves_brutas bit passes a 2-flop synchroniser before any other use.
REQ-013 Per bit: a counter increments each cycle the synchronised value differs from chaves_estaveis and clears to 0 on any match.
REQ-014 On the edge where the counter would reach DEBOUNCE_CICLOS, the chaves_estaveis bit takes the synchronised value and the counter clears.
REQ-015 A 0->1 transition of a chaves_estaveis bit sets the matching pendente bit on the next edge; 1->0 transitions generate nothing.
REQ-016 An edge arriving for a bit already set in pendente increments db_descartes, saturating at 15.
REQ-017 OCIOSO: if habilita=1 and pendente!=0, on the next edge load comando<=pendente, clear exactly the loaded bits, and go to VALIDO.
REQ-018 An edge setting a pendente bit in the same cycle as the load remains pending; it is not lost and not counted as a discard.
REQ-019 VALIDO: comando_valido=1 and comando is stable; on an edge with comando_ack=1, clear comando to 0 and return to OCIOSO.
REQ-020 Back-to-back commands are separated by at least one cycle in OCIOSO with comando_valido=0.
REQ-021 comando_ack outside VALIDO is ignored.
REQ-022 habilita=0: pendente is held at 0, new edges are ignored and not counted, and VALIDO drops to OCIOSO with comando cleared on the next edge.
REQ-023 Debouncing and chaves_estaveis keep operating regardless of habilita.
REQ-024 Latency: with a raw rise stable from sampling edge 1 onward, comando_valido is first high after edge DEBOUNCE_CICLOS+3.
REQ-025 A raw pulse shorter than DEBOUNCE_CICLOS synchronised cycles produces no stable change and no command.

Reset
REQ-026 reset=1 immediately clears the synchronisers, counters, chaves_estaveis, pendente, comando, comando_valido and db_descartes to 0, and sets the FSM to OCIOSO.
REQ-027 Reset mid-command discards every pending and presented command; no command is emitted after release unless a fresh debounced rise occurs.
REQ-028 A switch held high through reset release is debounced anew, then produces exactly one command.

Verification (DEBOUNCE_CICLOS=4)
REQ-029 habilita=1, chaves_brutas=100001 held 10 cycles, comando_ack tied 1 -> comando_valido high for one cycle after edge 7 with comando=100001, then 0.
REQ-030 Bit0 pulsed high for 3 cycles -> chaves_estaveis stays 000000 and comando_valido never rises.
REQ-031 comando_ack=0, bit1 pressed, then bit1 released and pressed again while VALIDO -> comando holds 000010, and db_descartes stays 0. After ack, a second command 000010 appears.
REQ-032 As REQ-031 but with a third press before ack -> db_descartes=1, and only two commands are emitted in total.
REQ-033 habilita dropped while VALIDO -> comando_valido=0 and comando=000000 one edge later; presses during habilita=0 emit nothing after re-enable.
REQ-034 reset asserted for 2 cycles while VALIDO with bit2 still held -> all outputs 0 during reset; exactly one 000100 command appears DEBOUNCE_CICLOS+3 edges after release.
